display_select: RTL and testbench

Output-stage multiplexer for the DDS board's dual 4-digit seven-segment display. Chooses between two pre-formatted display sources and drives the digit enables and the two 7-bit segment buses. Source A is the theoretical/real value pair (`dis_the4`, `dis_real4`, `dis_all`); source B is the alternate page (`p`, `q`). The block sits between the value-formatting logic and the board pins, runs on the 10 kHz scan clock, and inserts one blank cycle on every source change to prevent ghosting.

---
 rtl/display_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/display_select.sv | 69 ++++++
 tb/tb_display_select.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared widths and blank constants for the seven-segment output stage.
//   DIG_W      - digit-enable bus width (upper bank [7:4], lower bank [3:0])
//   SEG_W      - segment bus width (upper bank [13:7], lower bank [6:0])
//   BANK_SEG_W - segments per bank, {a,b,c,d,e,f,g} with a as MSB
package display_pkg;

  localparam int unsigned DIG_W      = 8;
  localparam int unsigned SEG_W      = 14;
  localparam int unsigned BANK_SEG_W = 7;

  localparam logic [DIG_W-1:0] BLANK_DIG = 8'h00;
  localparam logic [SEG_W-1:0] BLANK_SEG = 14'h0000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchronizer.
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/display_select.sv
// display_select: output-stage mux for the dual 4-digit seven-segment display.
//   clk       - 10 kHz scan clock
//   rst       - synchronous active-high reset
//   ctrl_dis  - asynchronous source select (1 = source A, 0 = source B)
//   dis_the4  - source A upper-bank digit enables
//   dis_real4 - source A lower-bank digit enables
//   dis_all   - source A segments, [13:7] upper bank, [6:0] lower bank
//   p         - source B digit enables, [7:4] upper bank, [3:0] lower bank
//   q         - source B segments, same layout as dis_all
//   dis_dig   - registered digit enables to the pins
//   dis_num   - registered segments to the pins
// One blank cycle is inserted on every source change so the previous source
// never ghosts onto the newly selected digits.
module display_select
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_dis,
  input  logic [3:0]       dis_the4,
  input  logic [3:0]       dis_real4,
  input  logic [SEG_W-1:0] dis_all,
  input  logic [DIG_W-1:0] p,
  input  logic [SEG_W-1:0] q,
  output logic [DIG_W-1:0] dis_dig,
  output logic [SEG_W-1:0] dis_num
);

  logic             mode;
  logic             mode_d;
  logic [DIG_W-1:0] dig_next;
  logic [SEG_W-1:0] num_next;

  sync_2ff u_sync_ctrl (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_dis),
    .q   (mode)
  );

  // A mode edge takes priority over both sources: blank for exactly that cycle.
  always_comb begin
    dig_next = BLANK_DIG;
    num_next = BLANK_SEG;
    if (mode != mode_d) begin
      dig_next = BLANK_DIG;
      num_next = BLANK_SEG;
    end else if (mode) begin
      dig_next = {dis_the4, dis_real4};
      num_next = dis_all;
    end else begin
      dig_next = p;
      num_next = q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_d  <= 1'b0;
      dis_dig <= BLANK_DIG;
      dis_num <= BLANK_SEG;
    end else begin
      mode_d  <= mode;
      dis_dig <= dig_next;
      dis_num <= num_next;
    end
  end

endmodule

// File: tb/tb_display_select.sv
// tb_display_select: directed and randomized checks of display_select against
// a history-based reference model of the select/blank behaviour.
module tb_display_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_dis;
  logic [3:0]  dis_the4;
  logic [3:0]  dis_real4;
  logic [13:0] dis_all;
  logic [7:0]  p;
  logic [13:0] q;
  logic [7:0]  dis_dig;
  logic [13:0] dis_num;

  int total = 0;
  int bad   = 0;

  // Per-edge history of sampled rst/ctrl_dis and the model's view of the
  // selected source after each edge.
  localparam int HMAX = 4096;
  bit rst_h  [HMAX];
  bit ctrl_h [HMAX];
  bit sel_h  [HMAX];  // source selected (synchronized) after edge n
  bit prev_h [HMAX];  // selection one edge earlier, as seen after edge n
  int n = 0;

  logic [21:0] exp_out;

  always #5 clk = ~clk;

  display_select dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_dis  (ctrl_dis),
    .dis_the4  (dis_the4),
    .dis_real4 (dis_real4),
    .dis_all   (dis_all),
    .p         (p),
    .q         (q),
    .dis_dig   (dis_dig),
    .dis_num   (dis_num)
  );

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Advance one edge, update the model from what was sampled, compare #1 later.
  task automatic step();
    logic [21:0] src_a;
    logic [21:0] src_b;
    @(posedge clk);
    if (n < HMAX - 1) n++;
    rst_h[n]  = rst;
    ctrl_h[n] = ctrl_dis;
    src_a = {dis_the4, dis_real4, dis_all};
    src_b = {p, q};
    // ctrl_dis takes two clean (non-reset) edges to become the selection.
    sel_h[n]  = (rst_h[n] || rst_h[n-1]) ? 1'b0 : ctrl_h[n-1];
    prev_h[n] = rst_h[n] ? 1'b0 : sel_h[n-1];
    if (rst_h[n])                    exp_out = '0;
    else if (sel_h[n-1] != prev_h[n-1]) exp_out = '0;
    else if (sel_h[n-1])             exp_out = src_a;
    else                             exp_out = src_b;
    #1;
    chk("model", {dis_dig, dis_num}, exp_out);
  endtask

  task automatic rand_data();
    dis_the4  = 4'($urandom);
    dis_real4 = 4'($urandom);
    dis_all   = 14'($urandom);
    p         = 8'($urandom);
    q         = 14'($urandom);
  endtask

  logic [21:0] a_val;
  logic [21:0] b_val;

  initial begin
    rst      = 1'b1;
    ctrl_dis = 1'($urandom);
    rand_data();

    // Reset held for 3 cycles with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset", {dis_dig, dis_num}, 22'h0);
      ctrl_dis = 1'($urandom);
      rand_data();
    end

    // Release with ctrl_dis=1: B, B, blank, A, A.
    ctrl_dis  = 1'b1;
    dis_the4  = 4'b1000;
    dis_real4 = 4'b1000;
    dis_all   = 14'b0110000_0110000;
    p         = 8'b0100_0000;
    q         = 14'b1101101_1111001;
    a_val     = {8'b1000_1000, 14'b0110000_0110000};
    b_val     = {8'b0100_0000, 14'b1101101_1111001};
    rst       = 1'b0;
    step(); chk("rel_b1", {dis_dig, dis_num}, b_val);
    step(); chk("rel_b2", {dis_dig, dis_num}, b_val);
    step(); chk("rel_blank", {dis_dig, dis_num}, 22'h0);
    step(); chk("steady_a1", {dis_dig, dis_num}, a_val);
    step(); chk("steady_a2", {dis_dig, dis_num}, a_val);

    // Data change in mode A appears at the next edge with no blank.
    dis_all = 14'b1111110_1111110;
    step(); chk("a_data", {dis_dig, dis_num}, {8'b1000_1000, 14'b1111110_1111110});
    a_val = {8'b1000_1000, 14'b1111110_1111110};

    // Toggle A->B sampled at edge k.
    ctrl_dis = 1'b0;
    step(); chk("tog_k", {dis_dig, dis_num}, a_val);
    step(); chk("tog_k1", {dis_dig, dis_num}, a_val);
    step(); chk("tog_blank", {dis_dig, dis_num}, 22'h0);
    step(); chk("tog_b", {dis_dig, dis_num}, b_val);

    // Source B follows each input change one cycle later.
    for (int i = 0; i < 4; i++) begin
      q = 14'($urandom);
      step(); chk("b_data", {dis_dig, dis_num}, {8'b0100_0000, q});
    end

    // Randomized phase: random data, occasional toggles and resets.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      if ($urandom_range(7, 0) == 0) ctrl_dis = ~ctrl_dis;
      rst = ($urandom_range(39, 0) == 0);
      step();
    end

    // Reset mid-stream in mode A, then release with ctrl_dis=1.
    rst       = 1'b0;
    ctrl_dis  = 1'b1;
    dis_the4  = 4'b0010;
    dis_real4 = 4'b0001;
    dis_all   = 14'b1011011_0110011;
    p         = 8'b0001_1000;
    q         = 14'b0011111_1110000;
    a_val     = {8'b0010_0001, 14'b1011011_0110011};
    b_val     = {8'b0001_1000, 14'b0011111_1110000};
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_a", {dis_dig, dis_num}, a_val);
    rst = 1'b1;
    step(); chk("mid_rst", {dis_dig, dis_num}, 22'h0);
    rst = 1'b0;
    step(); chk("post_b1", {dis_dig, dis_num}, b_val);
    step(); chk("post_b2", {dis_dig, dis_num}, b_val);
    step(); chk("post_blank", {dis_dig, dis_num}, 22'h0);
    step(); chk("post_a", {dis_dig, dis_num}, a_val);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
